// File: rtl/memory_load_fetch.sv
// memory_load_fetch: LSU load-request stage, one aligned bus read in flight, result held for the shifter.
// Optional LOAD_MISALIGN_CHECK_EN reports size-misaligned loads as errors without a bus access.
module memory_load_fetch #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int OFF_WIDTH  = DATA_WIDTH / 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_sign,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arsize,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pre_data,
  output logic [OFF_WIDTH:0]    out_offset,
  output logic                  out_is_byte,
  output logic                  out_is_half,
  output logic                  out_is_word,
  output logic                  out_is_double,
  output logic                  out_is_sign,
  output logic                  out_err
);
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("memory_load_fetch: DATA_WIDTH must be 32 or 64");
  end
  typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-OFF_WIDTH-2:0] addr_hi;
  logic drop, accept, misalign, bypass, r_take, r_keep;
`ifdef LOAD_MISALIGN_CHECK_EN
  assign misalign = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && |req_addr[1:0]) ||
                    (req_size == 2'b11 && |req_addr[2:0]);
`else
  assign misalign = 1'b0;
`endif
  assign bypass    = misalign || (DATA_WIDTH == 32 && req_size == 2'b11);
  assign req_ready = state == IDLE;
  assign arvalid   = state == AR;
  assign rready    = state == R;
  assign out_valid = state == OUT;
  assign accept    = req_valid && req_ready && !flush;
  assign r_take    = rready && rvalid;
  // a flush arriving alongside the R handshake still kills the result
  assign r_keep    = r_take && !drop && !flush;
  assign araddr    = {addr_hi, {(OFF_WIDTH + 1){1'b0}}};
  assign arsize    = DATA_WIDTH == 64 ? 3'd3 : 3'd2;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (bypass ? OUT : AR) : IDLE;
      AR:      state_nx = arready ? R : AR;
      R:       state_nx = r_take ? (r_keep ? OUT : IDLE) : R;
      default: state_nx = (flush || out_ready) ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_hi       <= '0;
      drop          <= 1'b0;
      out_pre_data  <= '0;
      out_offset    <= '0;
      out_is_byte   <= 1'b0;
      out_is_half   <= 1'b0;
      out_is_word   <= 1'b0;
      out_is_double <= 1'b0;
      out_is_sign   <= 1'b0;
      out_err       <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_hi       <= req_addr[ADDR_WIDTH-1:OFF_WIDTH+1];
        out_offset    <= req_addr[OFF_WIDTH:0];
        out_is_byte   <= req_size == 2'b00;
        out_is_half   <= req_size == 2'b01;
        out_is_word   <= req_size == 2'b10;
        out_is_double <= req_size == 2'b11;
        out_is_sign   <= req_sign;
        out_err       <= bypass;
        out_pre_data  <= '0;
        drop          <= 1'b0;
      end
      if (r_take) drop <= 1'b0;
      else if ((state == AR || state == R) && flush) drop <= 1'b1;
      if (r_keep) begin
        out_err      <= |rresp;
        out_pre_data <= |rresp ? '0 : rdata;
      end
    end
  end
endmodule
